des_key_schedule: RTL and testbench

- Consumes the 56-bit PC-1 sub-key produced by the key-check stage (valid/err interface).
- Generates the 16 DES round keys, one per cycle, in encrypt order (K1..K16) or decrypt order (K16..K1).
- Output is a 48-bit valid/ready stream that feeds the round datapath.
- Sits between key check and the Feistel round engine.

---
 rtl/des_pkg.sv | 38 +++
 rtl/des_pc2.sv | 15 +
 rtl/des_key_schedule.sv | 122 ++++++++++++
 tb/tb_des_key_schedule.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/des_pkg.sv
// Shared types, shift schedule and PC-2 table for the DES key schedule.
// Bit numbering follows FIPS 46: table entries are 1-based, bit 1 is the MSB.
package des_pkg;

  typedef logic [27:0] cd_half_t;
  typedef logic [55:0] sub_key_t;
  typedef logic [47:0] round_key_t;

  localparam int DES_ROUNDS = 16;
  localparam int NUM_ROUNDS = DES_ROUNDS;
  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  localparam logic [1:0] DES_SHIFT [DES_ROUNDS] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC2_TABLE [48] = '{
    14, 17, 11, 24,  1,  5,
     3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8,
    16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55,
    30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53,
    46, 42, 50, 36, 29, 32
  };

  // Shift amounts are only ever 1 or 2.
  function automatic cd_half_t rotl28(input cd_half_t x, input logic [1:0] n);
    return (n == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic cd_half_t rotr28(input cd_half_t x, input logic [1:0] n);
    return (n == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc2.sv
// Combinational PC-2 selection: 56-bit CD register to 48-bit round key.
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_i,
  output logic [47:0] key_o
);

  // Output bit n (1-based) takes CD bit PC2_TABLE[n-1], MSB-first numbering.
  for (genvar i = 0; i < 48; i++) begin : g_sel
    localparam int SRC = 56 - PC2_TABLE[i];
    assign key_o[47-i] = cd_i[SRC];
  end

endmodule

// File: rtl/des_key_schedule.sv
// DES round-key generator: one 48-bit key per cycle over a valid/ready stream,
// encrypt order K1..K16 or decrypt order K16..K1.
module des_key_schedule
  import des_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [55:0] sub_key_in,
  input  logic        sub_key_in_valid,
  input  logic        sub_key_err_in,
  input  logic        decrypt_in,
  output logic        sub_key_ready_out,
  output logic [47:0] round_key_out,
  output logic        round_key_out_valid,
  input  logic        round_key_ready_in,
  output logic [3:0]  round_idx_out,
  output logic        round_key_last_out,
  output logic        key_err_out,
  output logic        done_out
);

  typedef enum logic {S_IDLE, S_ROUND} state_e;

  state_e     state_q, state_d;
  sub_key_t   cd_q, cd_d, cd_nxt;
  round_key_t key_q, key_d, key_nxt;
  logic [3:0] idx_q, idx_d;
  logic       dec_q, dec_d;
  logic       key_err_q, key_err_d;
  logic       done_q, done_d;
  logic [1:0] shamt;

  // CD value for the next emission; the key is precomputed from it so the
  // output is always a register.
  always_comb begin
    shamt  = DES_SHIFT[0];
    cd_nxt = sub_key_in;
    if (state_q == S_IDLE) begin
      if (!decrypt_in) begin
        cd_nxt = {rotl28(sub_key_in[55:28], shamt), rotl28(sub_key_in[27:0], shamt)};
      end
    end else if (dec_q) begin
      shamt  = DES_SHIFT[4'd15 - idx_q];
      cd_nxt = {rotr28(cd_q[55:28], shamt), rotr28(cd_q[27:0], shamt)};
    end else begin
      shamt  = DES_SHIFT[idx_q + 4'd1];
      cd_nxt = {rotl28(cd_q[55:28], shamt), rotl28(cd_q[27:0], shamt)};
    end
  end

  des_pc2 u_pc2 (
    .cd_i  (cd_nxt),
    .key_o (key_nxt)
  );

  always_comb begin
    state_d   = state_q;
    cd_d      = cd_q;
    key_d     = key_q;
    idx_d     = idx_q;
    dec_d     = dec_q;
    key_err_d = 1'b0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (sub_key_in_valid) begin
          if (sub_key_err_in) begin
            key_err_d = 1'b1;
          end else begin
            state_d = S_ROUND;
            cd_d    = cd_nxt;
            key_d   = key_nxt;
            idx_d   = 4'd0;
            dec_d   = decrypt_in;
          end
        end
      end
      S_ROUND: begin
        if (round_key_ready_in) begin
          if (idx_q == LAST_IDX) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            cd_d  = cd_nxt;
            key_d = key_nxt;
            idx_d = idx_q + 4'd1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state_q   <= S_IDLE;
      cd_q      <= '0;
      key_q     <= '0;
      idx_q     <= '0;
      dec_q     <= 1'b0;
      key_err_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cd_q      <= cd_d;
      key_q     <= key_d;
      idx_q     <= idx_d;
      dec_q     <= dec_d;
      key_err_q <= key_err_d;
      done_q    <= done_d;
    end
  end

  assign sub_key_ready_out   = (state_q == S_IDLE);
  assign round_key_out_valid = (state_q == S_ROUND);
  assign round_key_out       = key_q;
  assign round_idx_out       = idx_q;
  assign round_key_last_out  = round_key_out_valid && (idx_q == LAST_IDX);
  assign key_err_out         = key_err_q;
  assign done_out            = done_q;

endmodule

// File: tb/tb_des_key_schedule.sv
// Directed bench for des_key_schedule using the FIPS 46 worked-example key.
module tb_des_key_schedule;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [55:0] sub_key_in;
  logic        sub_key_in_valid;
  logic        sub_key_err_in;
  logic        decrypt_in;
  logic        sub_key_ready_out;
  logic [47:0] round_key_out;
  logic        round_key_out_valid;
  logic        round_key_ready_in;
  logic [3:0]  round_idx_out;
  logic        round_key_last_out;
  logic        key_err_out;
  logic        done_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        dec;
    logic [3:0]  idx;
    logic [47:0] key;
    logic        last;
  } vec_t;

  vec_t        tbl [32];
  logic [47:0] enc_keys [16];

  localparam logic [55:0] FIPS_CD = 56'hF0CCAAF556678F;

  des_key_schedule dut (
    .clk_in              (clk_in),
    .rst_in              (rst_in),
    .sub_key_in          (sub_key_in),
    .sub_key_in_valid    (sub_key_in_valid),
    .sub_key_err_in      (sub_key_err_in),
    .decrypt_in          (decrypt_in),
    .sub_key_ready_out   (sub_key_ready_out),
    .round_key_out       (round_key_out),
    .round_key_out_valid (round_key_out_valid),
    .round_key_ready_in  (round_key_ready_in),
    .round_idx_out       (round_idx_out),
    .round_key_last_out  (round_key_last_out),
    .key_err_out         (key_err_out),
    .done_out            (done_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, act, exp);
    end
  endtask

  // Inputs change and outputs are sampled at the falling edge.
  task automatic cyc();
    @(posedge clk_in);
    @(negedge clk_in);
  endtask

  task automatic present(input logic dec);
    sub_key_in       = FIPS_CD;
    decrypt_in       = dec;
    sub_key_in_valid = 1'b1;
    sub_key_err_in   = 1'b0;
    cyc();
    sub_key_in_valid = 1'b0;
    sub_key_in       = '0;
    decrypt_in       = 1'b0;
  endtask

  // Presents at the current falling edge and drains all 16 keys with ready high.
  task automatic run_seq(input int base);
    present(tbl[base].dec);
    chk("busy_after_accept", {63'd0, sub_key_ready_out}, 64'd0);
    round_key_ready_in = 1'b1;
    for (int k = 0; k < 16; k++) begin
      chk($sformatf("valid[%0d]", base + k), {63'd0, round_key_out_valid}, 64'd1);
      chk($sformatf("key[%0d]", base + k), {16'd0, round_key_out}, {16'd0, tbl[base+k].key});
      chk($sformatf("idx[%0d]", base + k), {60'd0, round_idx_out}, {60'd0, tbl[base+k].idx});
      chk($sformatf("last[%0d]", base + k), {63'd0, round_key_last_out}, {63'd0, tbl[base+k].last});
      chk($sformatf("no_done[%0d]", base + k), {63'd0, done_out}, 64'd0);
      cyc();
    end
    chk("end_valid", {63'd0, round_key_out_valid}, 64'd0);
    chk("end_done", {63'd0, done_out}, 64'd1);
    chk("end_ready", {63'd0, sub_key_ready_out}, 64'd1);
  endtask

  initial begin
    int xfers;
    logic seen_done;

    enc_keys = '{
      48'h1B02EFFC7072, 48'h79AED9DBC9E5, 48'h55FC8A42CF99, 48'h72ADD6DB351D,
      48'h7CEC07EB53A8, 48'h63A53E507B2F, 48'hEC84B7F618BC, 48'hF78A3AC13BFB,
      48'hE0DBEBEDE781, 48'hB1F347BA464F, 48'h215FD3DED386, 48'h7571F59467E9,
      48'h97C5D1FABA41, 48'h5F43B7F2E73A, 48'hBF918D3D3F0A, 48'hCB3D8B0E17F5
    };
    for (int k = 0; k < 16; k++) begin
      tbl[k]    = '{dec: 1'b0, idx: 4'(k), key: enc_keys[k],    last: (k == 15)};
      tbl[16+k] = '{dec: 1'b1, idx: 4'(k), key: enc_keys[15-k], last: (k == 15)};
    end

    rst_in             = 1'b1;
    sub_key_in         = '0;
    sub_key_in_valid   = 1'b0;
    sub_key_err_in     = 1'b0;
    decrypt_in         = 1'b0;
    round_key_ready_in = 1'b0;
    @(negedge clk_in);
    cyc();
    chk("rst_ready", {63'd0, sub_key_ready_out}, 64'd1);
    chk("rst_valid", {63'd0, round_key_out_valid}, 64'd0);
    chk("rst_key", {16'd0, round_key_out}, 64'd0);
    chk("rst_idx", {60'd0, round_idx_out}, 64'd0);
    chk("rst_last", {63'd0, round_key_last_out}, 64'd0);
    chk("rst_err", {63'd0, key_err_out}, 64'd0);
    chk("rst_done", {63'd0, done_out}, 64'd0);
    rst_in = 1'b0;
    cyc();

    // Encrypt then decrypt, each from the table, with an idle cycle between.
    run_seq(0);
    cyc();
    run_seq(16);
    cyc();

    // Back-to-back: second key presented in the cycle ready returns.
    run_seq(0);
    run_seq(16);
    cyc();

    // Backpressure at idx 5.
    present(1'b0);
    round_key_ready_in = 1'b1;
    for (int k = 0; k < 5; k++) cyc();
    round_key_ready_in = 1'b0;
    for (int k = 0; k < 3; k++) begin
      cyc();
      chk("bp_valid", {63'd0, round_key_out_valid}, 64'd1);
      chk("bp_key", {16'd0, round_key_out}, {16'd0, enc_keys[5]});
      chk("bp_idx", {60'd0, round_idx_out}, 64'd5);
    end
    round_key_ready_in = 1'b1;
    xfers     = 5;
    seen_done = 1'b0;
    for (int c = 0; c < 40 && !seen_done; c++) begin
      if (done_out) begin
        seen_done = 1'b1;
      end else begin
        if (round_key_out_valid) begin
          if (xfers < 16)
            chk("bp_resume_key", {16'd0, round_key_out}, {16'd0, enc_keys[xfers]});
          xfers++;
        end
        cyc();
      end
    end
    chk("bp_done_seen", {63'd0, seen_done}, 64'd1);
    chk("bp_xfers", 64'(xfers), 64'd16);
    cyc();

    // Errored sub-key is dropped.
    sub_key_in       = FIPS_CD;
    sub_key_in_valid = 1'b1;
    sub_key_err_in   = 1'b1;
    cyc();
    sub_key_in_valid = 1'b0;
    sub_key_err_in   = 1'b0;
    chk("err_pulse", {63'd0, key_err_out}, 64'd1);
    chk("err_valid", {63'd0, round_key_out_valid}, 64'd0);
    chk("err_ready", {63'd0, sub_key_ready_out}, 64'd1);
    cyc();
    chk("err_pulse_end", {63'd0, key_err_out}, 64'd0);
    chk("err_still_idle", {63'd0, round_key_out_valid}, 64'd0);

    // Reset in the middle of a sequence.
    present(1'b0);
    round_key_ready_in = 1'b1;
    for (int k = 0; k < 9; k++) cyc();
    chk("pre_rst_idx", {60'd0, round_idx_out}, 64'd9);
    rst_in = 1'b1;
    cyc();
    rst_in = 1'b0;
    chk("mid_rst_valid", {63'd0, round_key_out_valid}, 64'd0);
    chk("mid_rst_done", {63'd0, done_out}, 64'd0);
    chk("mid_rst_ready", {63'd0, sub_key_ready_out}, 64'd1);
    chk("mid_rst_idx", {60'd0, round_idx_out}, 64'd0);
    cyc();
    chk("post_rst_done", {63'd0, done_out}, 64'd0);
    present(1'b0);
    chk("post_rst_valid", {63'd0, round_key_out_valid}, 64'd1);
    chk("post_rst_k1", {16'd0, round_key_out}, {16'd0, enc_keys[0]});

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
